// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types for the SPI slave: controller state encoding and the helper
// that sizes the bit counter from the frame length.
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // CS high, waiting for a frame
    ST_SHIFT = 2'd1,  // CS low, shifting bits
    ST_ABORT = 2'd2   // CS rose mid-frame, partial word dropped
  } spi_state_e;

  // Bits needed to count 0..frame_len-1 (never less than one bit).
  function automatic int cnt_width(input int frame_len);
    return (frame_len > 2) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
// Receive word FIFO, RX_DEPTH entries (power of two), clocked by SCLK.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_push, i_din      write request and data
//   i_pop              read request (ignored when empty)
//   o_dout             head of FIFO
//   o_empty, o_full    occupancy flags
// -----------------------------------------------------------------------------
module spi_rx_fifo #(
  parameter int WIDTH    = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [RX_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(RX_DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd];

  // Pointers are exactly PTR_W wide, so they wrap modulo RX_DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/spi_slave_param.sv
// -----------------------------------------------------------------------------
// spi_slave_param
// SPI mode-0 style slave clocked entirely by SCLK. MOSI is sampled on rising
// edges, MISO changes on falling edges. Received words go to a small FIFO;
// transmit words are taken from a valid/ready style input at each frame start.
// Optional feature macro: SPI_SLAVE_PARITY_EN adds an even-parity bit after
// the data bits in both directions and the sticky o_parity_err output.
// Ports:
//   i_sclk, i_rst_n            SPI clock, async active-low reset
//   i_cs_n, i_mosi, o_miso     SPI bus (chip select active low)
//   i_tx_data/i_tx_valid       next word to send; o_tx_ready pulses on use
//   o_rx_data/o_rx_valid       FIFO head; i_rx_ready pops it
//   o_frame_done               pulse after each completed frame
//   o_overflow, o_underrun     sticky errors, cleared by i_clear_err
//   o_parity_err               sticky parity error (parity build only)
// -----------------------------------------------------------------------------
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LSB_FIRST = 1,
  parameter int               RX_DEPTH  = 4,
  parameter logic [WIDTH-1:0] FILL      = '0
) (
  input  logic             i_sclk,
  input  logic             i_rst_n,
  input  logic             i_cs_n,
  input  logic             i_mosi,
  output logic             o_miso,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic             o_frame_done,
  output logic             o_overflow,
  output logic             o_underrun,
`ifdef SPI_SLAVE_PARITY_EN
  output logic             o_parity_err,
`endif
  input  logic             i_clear_err
);

`ifdef SPI_SLAVE_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int              CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  spi_state_e           r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [WIDTH-1:0]     r_rx_sr;
  logic [FRAME_LEN-1:0] r_tx_ord;
  logic                 r_miso;
  logic                 r_tx_ready, r_frame_done, r_overflow, r_underrun;
`ifdef SPI_SLAVE_PARITY_EN
  logic                 r_parity_err;
`endif

  logic [WIDTH-1:0]     w_tx_word, w_rx_next, w_rx_word;
  logic [FRAME_LEN-1:0] w_tx_ord;
  logic                 w_start, w_last, w_abort, w_full, w_empty, w_ovf;

  // Transmit word laid out in wire order: w_tx_ord[k] is the k-th bit sent.
  assign w_tx_word = i_tx_valid ? i_tx_data : FILL;
  for (genvar g = 0; g < WIDTH; g++) begin : g_ord
    assign w_tx_ord[g] = (LSB_FIRST != 0) ? w_tx_word[g] : w_tx_word[WIDTH-1-g];
  end
`ifdef SPI_SLAVE_PARITY_EN
  assign w_tx_ord[WIDTH] = ^w_tx_word;
`endif

  assign w_rx_next = (LSB_FIRST != 0) ? {i_mosi, r_rx_sr[WIDTH-1:1]}
                                      : {r_rx_sr[WIDTH-2:0], i_mosi};
`ifdef SPI_SLAVE_PARITY_EN
  // Last edge carries parity; the data word is already complete.
  assign w_rx_word = r_rx_sr;
`else
  assign w_rx_word = w_rx_next;
`endif

  assign w_start = !i_cs_n && (r_bit_cnt == '0);
  assign w_last  = !i_cs_n && (r_bit_cnt == LAST);
  assign w_abort = i_cs_n && (r_state == ST_SHIFT) && (r_bit_cnt != '0);
  // When full, the FIFO is non-empty, so rx_ready alone means a pop frees a slot.
  assign w_ovf   = w_last && w_full && !i_rx_ready;

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_rx_sr      <= '0;
      r_tx_ord     <= '0;
      r_tx_ready   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_underrun   <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_tx_ready   <= 1'b0;
      r_frame_done <= 1'b0;
      // Clear first so that an error raised on this same edge overrides it.
      if (i_clear_err) begin
        r_overflow   <= 1'b0;
        r_underrun   <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end
      if (i_cs_n) begin
        r_state   <= w_abort ? ST_ABORT : ST_IDLE;
        r_bit_cnt <= '0;
        if (w_abort) r_rx_sr <= '0;
      end else begin
        r_state <= ST_SHIFT;
`ifdef SPI_SLAVE_PARITY_EN
        if (r_bit_cnt != LAST) r_rx_sr <= w_rx_next;
`else
        r_rx_sr <= w_rx_next;
`endif
        if (w_start) begin
          r_tx_ord <= w_tx_ord;
          if (i_tx_valid) r_tx_ready <= 1'b1;
          else            r_underrun <= 1'b1;
        end
        if (w_last) begin
          r_bit_cnt    <= '0;
          r_frame_done <= 1'b1;
          if (w_ovf) r_overflow <= 1'b1;
`ifdef SPI_SLAVE_PARITY_EN
          if ((^r_rx_sr) != i_mosi) r_parity_err <= 1'b1;
`endif
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  // Falling edge: present the bit for the position the counter now points at.
  always_ff @(negedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) r_miso <= 1'b0;
    else          r_miso <= r_tx_ord[r_bit_cnt];
  end

  // Bit 0 comes straight from the input word so it is valid before the first
  // rising edge of the frame.
  assign o_miso = (i_rst_n && !i_cs_n) ? ((r_bit_cnt == '0) ? w_tx_ord[0] : r_miso)
                                       : 1'b0;

  spi_rx_fifo #(.WIDTH(WIDTH), .RX_DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (i_sclk),
    .i_rst_n (i_rst_n),
    .i_push  (w_last),
    .i_din   (w_rx_word),
    .i_pop   (i_rx_ready),
    .o_dout  (o_rx_data),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_rx_valid   = !w_empty;
  assign o_tx_ready   = r_tx_ready;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;
  assign o_underrun   = r_underrun;
`ifdef SPI_SLAVE_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_param
// Two slaves: A (8-bit, LSB first, FILL=0xFF) and B (16-bit, MSB first).
// Expected receive words are queued as frames are sent; monitors pop and
// compare whenever a slave presents a word with rx_ready high.
// -----------------------------------------------------------------------------
module tb_spi_slave_param;
  localparam int WA = 8;
  localparam int WB = 16;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLA = WA + PB;
  localparam int FLB = WB + PB;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  logic          cs_a, mosi_a, miso_a, txv_a, txr_a, rxv_a, rxr_a, fd_a, ovf_a, und_a, clr_a;
  logic [WA-1:0] txd_a, rxd_a;
  logic          cs_b, mosi_b, miso_b, txv_b, txr_b, rxv_b, rxr_b, fd_b, ovf_b, und_b, clr_b;
  logic [WB-1:0] txd_b, rxd_b;
`ifdef SPI_SLAVE_PARITY_EN
  logic          perr_a, perr_b;
`endif

  spi_slave_param #(.WIDTH(WA), .LSB_FIRST(1), .RX_DEPTH(4), .FILL(8'hFF)) u_dut_a (
    .i_sclk(sclk), .i_rst_n(rst_n), .i_cs_n(cs_a), .i_mosi(mosi_a), .o_miso(miso_a),
    .i_tx_data(txd_a), .i_tx_valid(txv_a), .o_tx_ready(txr_a),
    .o_rx_data(rxd_a), .o_rx_valid(rxv_a), .i_rx_ready(rxr_a),
    .o_frame_done(fd_a), .o_overflow(ovf_a), .o_underrun(und_a),
`ifdef SPI_SLAVE_PARITY_EN
    .o_parity_err(perr_a),
`endif
    .i_clear_err(clr_a));

  spi_slave_param #(.WIDTH(WB), .LSB_FIRST(0), .RX_DEPTH(4), .FILL(16'h0000)) u_dut_b (
    .i_sclk(sclk), .i_rst_n(rst_n), .i_cs_n(cs_b), .i_mosi(mosi_b), .o_miso(miso_b),
    .i_tx_data(txd_b), .i_tx_valid(txv_b), .o_tx_ready(txr_b),
    .o_rx_data(rxd_b), .o_rx_valid(rxv_b), .i_rx_ready(rxr_b),
    .o_frame_done(fd_b), .o_overflow(ovf_b), .o_underrun(und_b),
`ifdef SPI_SLAVE_PARITY_EN
    .o_parity_err(perr_b),
`endif
    .i_clear_err(clr_b));

  int n_checks = 0;
  int n_fail   = 0;
  int fdc_a = 0, txc_a = 0, fdc_b = 0;
  logic [WA-1:0] q_a[$];
  logic [WB-1:0] q_b[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitors sample 2 time units after the falling edge, well clear of the
  // rising edge that performs the pop.
  always @(negedge sclk) begin
    #2;
    if (rxv_a && rxr_a) begin
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx_a: got unexpected word %h expected none", rxd_a);
      end else check("rx_a", 32'(rxd_a), 32'(q_a.pop_front()));
    end
    if (fd_a)  fdc_a++;
    if (txr_a) txc_a++;
  end

  always @(negedge sclk) begin
    #2;
    if (rxv_b && rxr_b) begin
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx_b: got unexpected word %h expected none", rxd_b);
      end else check("rx_b", 32'(rxd_b), 32'(q_b.pop_front()));
    end
    if (fd_b) fdc_b++;
  end

  // One frame on A. keep_cs leaves CS low so the next call continues
  // back-to-back; pop_last raises rx_ready only for the frame's last edge.
  task automatic xfer_a(input logic [WA-1:0] w, input logic par_bad, input bit keep_cs,
                        input bit pop_last, output logic [WA-1:0] got, output logic got_par);
    got = '0; got_par = 1'b0;
    for (int i = 0; i < FLA; i++) begin
      @(negedge sclk);
      cs_a = 1'b0;
      if (i < WA) mosi_a = w[i];
      else        mosi_a = (^w) ^ par_bad;
      if (pop_last && i == FLA-1) rxr_a = 1'b1;
      #3;
      if (i < WA) got[i] = miso_a;
      else        got_par = miso_a;
    end
    if (!keep_cs) begin
      @(negedge sclk);
      if (pop_last) rxr_a = 1'b0;
      cs_a = 1'b1; mosi_a = 1'b0;
      #3;
    end
  endtask

  task automatic xfer_b(input logic [WB-1:0] w, input bit keep_cs,
                        output logic [WB-1:0] got, output logic got_par);
    got = '0; got_par = 1'b0;
    for (int i = 0; i < FLB; i++) begin
      @(negedge sclk);
      cs_b = 1'b0;
      if (i < WB) mosi_b = w[WB-1-i];
      else        mosi_b = ^w;
      #3;
      if (i < WB) got[WB-1-i] = miso_b;
      else        got_par = miso_b;
    end
    if (!keep_cs) begin
      @(negedge sclk);
      cs_b = 1'b1; mosi_b = 1'b0;
      #3;
    end
  endtask

  task automatic clear_a();
    @(negedge sclk); clr_a = 1'b1;
    @(negedge sclk); clr_a = 1'b0;
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WA-1:0] ga;
    logic [WB-1:0] gb1, gb2;
    logic          pa, pb1, pb2;
    int f0, t0;
    cs_a = 1'b1; mosi_a = 1'b0; txd_a = '0; txv_a = 1'b0; rxr_a = 1'b1; clr_a = 1'b0;
    cs_b = 1'b1; mosi_b = 1'b0; txd_b = '0; txv_b = 1'b0; rxr_b = 1'b1; clr_b = 1'b0;

    // Reset: CS low with FILL bit0=1 would drive MISO high if not held in reset.
    repeat (3) @(posedge sclk);
    cs_a = 1'b0;
    #1;
    check("rst_miso", 32'(miso_a), 0);
    check("rst_rx_valid", 32'(rxv_a), 0);
    check("rst_frame_done", 32'(fd_a), 0);
    check("rst_tx_ready", 32'(txr_a), 0);
    check("rst_overflow", 32'(ovf_a), 0);
    check("rst_underrun", 32'(und_a), 0);
    cs_a = 1'b1;
    @(negedge sclk); rst_n = 1'b1;

    // Basic frame: receive 0x53, transmit 0x09 (bits 1,0,0,1,0,0,0,0).
    @(negedge sclk); txd_a = 8'h09; txv_a = 1'b1;
    f0 = fdc_a; t0 = txc_a;
    q_a.push_back(8'h53);
    xfer_a(8'h53, 1'b0, 0, 0, ga, pa);
    check("t1_miso", 32'(ga), 32'h09);
    check("t1_frame_done", 32'(fdc_a - f0), 1);
    check("t1_tx_ready", 32'(txc_a - t0), 1);
    check("t1_underrun", 32'(und_a), 0);
`ifdef SPI_SLAVE_PARITY_EN
    check("t1_miso_par", 32'(pa), 32'(^8'h09));
    check("t1_parity_err", 32'(perr_a), 0);
`endif

    // Underrun: no tx word, FILL goes out, tx_ready stays low.
    @(negedge sclk); txv_a = 1'b0;
    t0 = txc_a;
    q_a.push_back(8'hA6);
    xfer_a(8'hA6, 1'b0, 0, 0, ga, pa);
    check("und_miso", 32'(ga), 32'hFF);
    check("und_flag", 32'(und_a), 1);
    check("und_tx_ready", 32'(txc_a - t0), 0);
    clear_a();
    check("und_cleared", 32'(und_a), 0);

    // Abort after 3 bits, then a full 0x3C frame.
    @(negedge sclk); txd_a = 8'h5A; txv_a = 1'b1;
    f0 = fdc_a;
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk); cs_a = 1'b0; mosi_a = 1'b1;
    end
    @(negedge sclk); cs_a = 1'b1; mosi_a = 1'b0;
    repeat (2) @(negedge sclk);
    #3;
    check("abort_frame_done", 32'(fdc_a - f0), 0);
    check("abort_rx_valid", 32'(rxv_a), 0);
    q_a.push_back(8'h3C);
    xfer_a(8'h3C, 1'b0, 0, 0, ga, pa);
    check("abort_next_miso", 32'(ga), 32'h5A);
    check("abort_next_fd", 32'(fdc_a - f0), 1);

    // Overflow: five back-to-back frames with nothing popped.
    @(negedge sclk); rxr_a = 1'b0;
    f0 = fdc_a;
    xfer_a(8'h11, 1'b0, 1, 0, ga, pa);
    xfer_a(8'h22, 1'b0, 1, 0, ga, pa);
    xfer_a(8'h33, 1'b0, 1, 0, ga, pa);
    xfer_a(8'h44, 1'b0, 1, 0, ga, pa);
    @(posedge sclk); #1;
    check("ovf_before_5th", 32'(ovf_a), 0);
    check("ovf_rx_valid", 32'(rxv_a), 1);
    xfer_a(8'h55, 1'b0, 0, 0, ga, pa);
    check("ovf_after_5th", 32'(ovf_a), 1);
    check("ovf_frame_done", 32'(fdc_a - f0), 5);
    q_a.push_back(8'h11); q_a.push_back(8'h22);
    q_a.push_back(8'h33); q_a.push_back(8'h44);
    clear_a();
    check("ovf_cleared", 32'(ovf_a), 0);

    // Full FIFO with pop and push on the same edge: no overflow.
    xfer_a(8'h66, 1'b0, 0, 1, ga, pa);
    check("full_pushpop_ovf", 32'(ovf_a), 0);
    q_a.push_back(8'h66);
    @(negedge sclk); rxr_a = 1'b1;
    for (int k = 0; k < 20 && q_a.size() != 0; k++) @(negedge sclk);
    #3;
    check("drain_a", 32'(q_a.size()), 0);
    check("drain_rx_valid", 32'(rxv_a), 0);

`ifdef SPI_SLAVE_PARITY_EN
    // 0x07 with parity bit 0 (even parity would be 1).
    q_a.push_back(8'h07);
    xfer_a(8'h07, 1'b1, 0, 0, ga, pa);
    repeat (3) @(negedge sclk);
    #3;
    check("par_err_set", 32'(perr_a), 1);
    check("par_word_kept", 32'(q_a.size()), 0);
    clear_a();
    check("par_err_cleared", 32'(perr_a), 0);
`endif

    // B: 16-bit MSB first, two frames back-to-back.
    @(negedge sclk); txd_b = 16'h1234; txv_b = 1'b1;
    f0 = fdc_b;
    q_b.push_back(16'hA5C3); q_b.push_back(16'h8001);
    xfer_b(16'hA5C3, 1, gb1, pb1);
    txd_b = 16'hBEEF;
    xfer_b(16'h8001, 0, gb2, pb2);
    check("b_miso1", 32'(gb1), 32'h1234);
    check("b_miso2", 32'(gb2), 32'hBEEF);
    check("b_frame_done", 32'(fdc_b - f0), 2);
    check("b_underrun", 32'(und_b), 0);
    check("b_overflow", 32'(ovf_b), 0);
`ifdef SPI_SLAVE_PARITY_EN
    check("b_par1", 32'(pb1), 32'(^16'h1234));
    check("b_par2", 32'(pb2), 32'(^16'hBEEF));
    check("b_parity_err", 32'(perr_b), 0);
`endif
    for (int k = 0; k < 20 && q_b.size() != 0; k++) @(negedge sclk);
    #3;
    check("drain_b", 32'(q_b.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
